// File: rtl/mwc_pkt_writer.sv
// rtl/mwc_pkt_writer.sv - manager write controller: buffers NoC packets and turns accepted ones into sequential memory writes
module mwc_pkt_writer #(
    parameter int                DATA_W   = 64,
    parameter int                ADDR_W   = 24,
    parameter int                MGR_ID_W = 6,
    parameter int                TYPE_W   = 4,
    parameter int                PTYPE_W  = 4,
    parameter logic [TYPE_W-1:0] WR_TYPE  = 4'd2,
    parameter int                DEPTH    = 8
) (
    input  logic                clk,
    input  logic                reset_poweron,
    input  logic                mcntl__mwc__valid,
    input  logic [1:0]          mcntl__mwc__cntl,
    input  logic [TYPE_W-1:0]   mcntl__mwc__type,
    input  logic [PTYPE_W-1:0]  mcntl__mwc__ptype,
    input  logic [DATA_W-1:0]   mcntl__mwc__data,
    input  logic                mcntl__mwc__pvalid,
    input  logic [MGR_ID_W-1:0] mcntl__mwc__mgrId,
    output logic                mwc__mcntl__ready,
    input  logic [MGR_ID_W-1:0] sys__mgr__mgrId,
    output logic                mwc__mem__wr_en,
    output logic [ADDR_W-1:0]   mwc__mem__wr_addr,
    output logic [DATA_W-1:0]   mwc__mem__wr_data,
    input  logic                mem__mwc__wr_ready,
    output logic [15:0]         mwc__stat__pkt_cnt,
    output logic [15:0]         mwc__stat__drop_cnt,
    output logic                mwc__stat__err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 2 + TYPE_W + 1 + MGR_ID_W + DATA_W;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DROP} state_t;

    logic [ENT_W-1:0]    fifo_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count, count_n;
    logic                full, push, pop, overflow;

    logic [1:0]          h_cntl;
    logic [TYPE_W-1:0]   h_type;
    logic                h_pvalid;
    logic [MGR_ID_W-1:0] h_mgr;
    logic [DATA_W-1:0]   h_data;
    logic                is_som, is_eom, hdr_ok;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic                do_wr, set_err, pkt_inc, drop_inc, handle_hdr;

    // payload type travels with the packet but has no role in this block
    logic                unused_ptype;
    assign unused_ptype = ^mcntl__mwc__ptype;

    assign full     = (count == CNT_W'(DEPTH));
    assign pop      = (count != '0) && (!mwc__mem__wr_en || mem__mwc__wr_ready);
    assign push     = mcntl__mwc__valid && (!full || pop);
    assign overflow = mcntl__mwc__valid && full && !pop;
    assign count_n  = count + CNT_W'(push) - CNT_W'(pop);

    assign {h_cntl, h_type, h_pvalid, h_mgr, h_data} = fifo_mem[rd_ptr];
    assign is_som = h_cntl[0];
    assign is_eom = h_cntl[1];
    assign hdr_ok = (h_mgr == sys__mgr__mgrId) && (h_type == WR_TYPE);

    // FIFO storage; words offered during reset are never stored
    always_ff @(posedge clk) begin
        if (reset_poweron && push)
            fifo_mem[wr_ptr] <= {mcntl__mwc__cntl, mcntl__mwc__type, mcntl__mwc__pvalid,
                                 mcntl__mwc__mgrId, mcntl__mwc__data};
    end

    // FIFO pointers, occupancy and the registered advisory ready
    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            mwc__mcntl__ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count             <= count_n;
            mwc__mcntl__ready <= (count_n <= CNT_W'(DEPTH - 4));
        end
    end

    // packet FSM: classify each popped word; a stray header restarts as a fresh header
    always_comb begin
        state_n    = state;
        addr_n     = addr_q;
        do_wr      = 1'b0;
        set_err    = 1'b0;
        pkt_inc    = 1'b0;
        drop_inc   = 1'b0;
        handle_hdr = 1'b0;
        if (pop) begin
            case (state)
                ST_IDLE: begin
                    if (is_som) handle_hdr = 1'b1;
                    else        set_err    = 1'b1;
                end
                ST_DATA: begin
                    if (is_som) begin
                        set_err    = 1'b1;
                        handle_hdr = 1'b1;
                    end else begin
                        if (h_pvalid) begin
                            do_wr  = 1'b1;
                            addr_n = addr_q + ADDR_W'(1);
                        end
                        if (is_eom) begin
                            state_n = ST_IDLE;
                            pkt_inc = 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (is_som) begin
                        set_err    = 1'b1;
                        handle_hdr = 1'b1;
                    end else if (is_eom) begin
                        state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
            if (handle_hdr) begin
                if (hdr_ok) begin
                    addr_n  = h_data[ADDR_W-1:0];
                    state_n = is_eom ? ST_IDLE : ST_DATA;
                    pkt_inc = is_eom;
                end else begin
                    drop_inc = 1'b1;
                    state_n  = is_eom ? ST_IDLE : ST_DROP;
                end
            end
        end
    end

    // state, running address and statistics
    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            state               <= ST_IDLE;
            addr_q              <= '0;
            mwc__stat__pkt_cnt  <= '0;
            mwc__stat__drop_cnt <= '0;
            mwc__stat__err      <= 1'b0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            if (pkt_inc && mwc__stat__pkt_cnt != 16'hFFFF)
                mwc__stat__pkt_cnt <= mwc__stat__pkt_cnt + 16'd1;
            if (drop_inc && mwc__stat__drop_cnt != 16'hFFFF)
                mwc__stat__drop_cnt <= mwc__stat__drop_cnt + 16'd1;
            if (set_err || overflow)
                mwc__stat__err <= 1'b1;
        end
    end

    // registered write port; holds everything while the memory stalls
    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            mwc__mem__wr_en   <= 1'b0;
            mwc__mem__wr_addr <= '0;
            mwc__mem__wr_data <= '0;
        end else if (!mwc__mem__wr_en || mem__mwc__wr_ready) begin
            mwc__mem__wr_en <= do_wr;
            if (do_wr) begin
                mwc__mem__wr_addr <= addr_q;
                mwc__mem__wr_data <= h_data;
            end
        end
    end
endmodule

// File: tb/tb_mwc_pkt_writer.sv
// tb/tb_mwc_pkt_writer.sv - directed self-checking bench for mwc_pkt_writer
module tb_mwc_pkt_writer;
    localparam logic [5:0] MY_ID = 6'd5;
    localparam logic [3:0] WR    = 4'd2;
    localparam logic [1:0] SOM   = 2'b01;
    localparam logic [1:0] MOM   = 2'b00;
    localparam logic [1:0] EOM   = 2'b10;

    logic        clk = 1'b0;
    logic        reset_poweron = 1'b0;
    logic        mcntl__mwc__valid = 1'b0;
    logic [1:0]  mcntl__mwc__cntl = 2'b00;
    logic [3:0]  mcntl__mwc__type = 4'd0;
    logic [3:0]  mcntl__mwc__ptype = 4'd0;
    logic [63:0] mcntl__mwc__data = 64'd0;
    logic        mcntl__mwc__pvalid = 1'b0;
    logic [5:0]  mcntl__mwc__mgrId = 6'd0;
    logic        mwc__mcntl__ready;
    logic [5:0]  sys__mgr__mgrId = MY_ID;
    logic        mwc__mem__wr_en;
    logic [23:0] mwc__mem__wr_addr;
    logic [63:0] mwc__mem__wr_data;
    logic        mem__mwc__wr_ready = 1'b1;
    logic [15:0] mwc__stat__pkt_cnt;
    logic [15:0] mwc__stat__drop_cnt;
    logic        mwc__stat__err;

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc = 0;
    logic [87:0] wq[$];
    int          wt[$];

    always #5 clk = ~clk;

    mwc_pkt_writer dut (
        .clk                 (clk),
        .reset_poweron       (reset_poweron),
        .mcntl__mwc__valid   (mcntl__mwc__valid),
        .mcntl__mwc__cntl    (mcntl__mwc__cntl),
        .mcntl__mwc__type    (mcntl__mwc__type),
        .mcntl__mwc__ptype   (mcntl__mwc__ptype),
        .mcntl__mwc__data    (mcntl__mwc__data),
        .mcntl__mwc__pvalid  (mcntl__mwc__pvalid),
        .mcntl__mwc__mgrId   (mcntl__mwc__mgrId),
        .mwc__mcntl__ready   (mwc__mcntl__ready),
        .sys__mgr__mgrId     (sys__mgr__mgrId),
        .mwc__mem__wr_en     (mwc__mem__wr_en),
        .mwc__mem__wr_addr   (mwc__mem__wr_addr),
        .mwc__mem__wr_data   (mwc__mem__wr_data),
        .mem__mwc__wr_ready  (mem__mwc__wr_ready),
        .mwc__stat__pkt_cnt  (mwc__stat__pkt_cnt),
        .mwc__stat__drop_cnt (mwc__stat__drop_cnt),
        .mwc__stat__err      (mwc__stat__err)
    );

    // accepted writes, tagged with the index of the negedge they were seen on
    always @(negedge clk) begin
        if (mwc__mem__wr_en && mem__mwc__wr_ready) begin
            wq.push_back({mwc__mem__wr_addr, mwc__mem__wr_data});
            wt.push_back(ncyc);
        end
        ncyc <= ncyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [1:0] c, input logic [3:0] t, input logic [5:0] m,
                             input logic [63:0] d, input logic pv);
        int guard = 0;
        while (!mwc__mcntl__ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (guard >= 200) begin
            n_bad++;
            $display("FAIL send_ready got timeout exp ready=1");
        end
        mcntl__mwc__cntl   = c;
        mcntl__mwc__type   = t;
        mcntl__mwc__mgrId  = m;
        mcntl__mwc__data   = d;
        mcntl__mwc__pvalid = pv;
        mcntl__mwc__valid  = 1'b1;
        @(posedge clk); #1;
        mcntl__mwc__valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset_poweron = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (mwc__mcntl__ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b exp 0", mwc__mcntl__ready); end
        n_cmp++; if (mwc__mem__wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en got %b exp 0", mwc__mem__wr_en); end
        n_cmp++; if (mwc__mem__wr_addr !== 24'h0) begin n_bad++; $display("FAIL rst_addr got %h exp 0", mwc__mem__wr_addr); end
        n_cmp++; if (mwc__mem__wr_data !== 64'h0) begin n_bad++; $display("FAIL rst_data got %h exp 0", mwc__mem__wr_data); end
        n_cmp++; if (mwc__stat__pkt_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_pkt got %h exp 0", mwc__stat__pkt_cnt); end
        n_cmp++; if (mwc__stat__drop_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_drop got %h exp 0", mwc__stat__drop_cnt); end
        n_cmp++; if (mwc__stat__err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b exp 0", mwc__stat__err); end
        reset_poweron = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (mwc__mcntl__ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_release got %b exp 1", mwc__mcntl__ready); end
    endtask

    task automatic test_basic();
        logic [87:0] ew [3];
        logic [87:0] got;
        int tag;
        ew[0] = {24'h000100, 64'hA};
        ew[1] = {24'h000101, 64'hB};
        ew[2] = {24'h000102, 64'hC};
        wq.delete(); wt.delete();
        send_word(SOM, WR, MY_ID, 64'h000100, 1'b0);
        tag = ncyc;
        send_word(MOM, WR, MY_ID, 64'hA, 1'b1);
        send_word(MOM, WR, MY_ID, 64'hB, 1'b1);
        send_word(EOM, WR, MY_ID, 64'hC, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (wq.size() != 3) begin n_bad++; $display("FAIL basic_count got %0d exp 3", wq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < wq.size()) ? wq[i] : '1;
            n_cmp++; if (got !== ew[i]) begin n_bad++; $display("FAIL basic_wr%0d got %h exp %h", i, got, ew[i]); end
        end
        // header sampled at edge N: first write visible in the cycle after edge N+2
        n_cmp++;
        if (wt.size() == 0 || wt[0] != tag + 2) begin
            n_bad++; $display("FAIL basic_latency got %0d exp %0d", (wt.size() == 0) ? -1 : wt[0], tag + 2);
        end
        n_cmp++; if (mwc__stat__pkt_cnt !== 16'd1) begin n_bad++; $display("FAIL basic_pkt got %0d exp 1", mwc__stat__pkt_cnt); end
    endtask

    task automatic test_filter();
        wq.delete(); wt.delete();
        send_word(SOM, WR, 6'd9, 64'h000700, 1'b0);
        send_word(MOM, WR, 6'd9, 64'h1, 1'b1);
        send_word(MOM, WR, 6'd9, 64'h2, 1'b1);
        send_word(EOM, WR, 6'd9, 64'h3, 1'b1);
        send_word(SOM, 4'd3, MY_ID, 64'h000800, 1'b0);
        send_word(MOM, 4'd3, MY_ID, 64'h4, 1'b1);
        send_word(MOM, 4'd3, MY_ID, 64'h5, 1'b1);
        send_word(EOM, 4'd3, MY_ID, 64'h6, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (wq.size() != 0) begin n_bad++; $display("FAIL filter_writes got %0d exp 0", wq.size()); end
        n_cmp++; if (mwc__stat__drop_cnt !== 16'd2) begin n_bad++; $display("FAIL filter_drop got %0d exp 2", mwc__stat__drop_cnt); end
        n_cmp++; if (mwc__stat__err !== 1'b0) begin n_bad++; $display("FAIL filter_err got %b exp 0", mwc__stat__err); end
        n_cmp++; if (mwc__stat__pkt_cnt !== 16'd1) begin n_bad++; $display("FAIL filter_pkt got %0d exp 1", mwc__stat__pkt_cnt); end
    endtask

    task automatic test_backpressure();
        logic        saw_low = 1'b0;
        logic [87:0] got;
        logic [87:0] ew;
        int          guard = 0;
        wq.delete(); wt.delete();
        mem__mwc__wr_ready = 1'b0;
        fork
            begin
                send_word(SOM, WR, MY_ID, 64'h000200, 1'b0);
                for (int i = 0; i < 12; i++)
                    send_word((i == 11) ? EOM : MOM, WR, MY_ID, 64'hB000 + 64'(i), 1'b1);
            end
            begin
                while (!mwc__mem__wr_en && guard < 50) begin
                    @(posedge clk); #1;
                    guard++;
                end
                n_cmp++; if (guard >= 50) begin n_bad++; $display("FAIL bp_first_wr got timeout exp wr_en"); end
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    n_cmp++;
                    if ({mwc__mem__wr_en, mwc__mem__wr_addr, mwc__mem__wr_data} !== {1'b1, 24'h000200, 64'hB000}) begin
                        n_bad++;
                        $display("FAIL bp_hold%0d got %b/%h/%h exp 1/000200/b000", k,
                                 mwc__mem__wr_en, mwc__mem__wr_addr, mwc__mem__wr_data);
                    end
                    if (!mwc__mcntl__ready) saw_low = 1'b1;
                end
                @(posedge clk); #1;
                mem__mwc__wr_ready = 1'b1;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (saw_low !== 1'b1) begin n_bad++; $display("FAIL bp_ready_low got %b exp 1", saw_low); end
        n_cmp++; if (wq.size() != 12) begin n_bad++; $display("FAIL bp_count got %0d exp 12", wq.size()); end
        for (int i = 0; i < 12; i++) begin
            ew  = {24'h000200 + 24'(i), 64'hB000 + 64'(i)};
            got = (i < wq.size()) ? wq[i] : '1;
            n_cmp++; if (got !== ew) begin n_bad++; $display("FAIL bp_wr%0d got %h exp %h", i, got, ew); end
        end
        n_cmp++; if (mwc__stat__err !== 1'b0) begin n_bad++; $display("FAIL bp_err got %b exp 0", mwc__stat__err); end
        n_cmp++; if (mwc__stat__pkt_cnt !== 16'd2) begin n_bad++; $display("FAIL bp_pkt got %0d exp 2", mwc__stat__pkt_cnt); end
    endtask

    task automatic test_wrap_sparse();
        logic [87:0] ew [3];
        logic [87:0] got;
        ew[0] = {24'hFFFFFE, 64'h1};
        ew[1] = {24'hFFFFFF, 64'h3};
        ew[2] = {24'h000000, 64'h4};
        wq.delete(); wt.delete();
        send_word(SOM, WR, MY_ID, 64'hFFFFFE, 1'b0);
        send_word(MOM, WR, MY_ID, 64'h1, 1'b1);
        send_word(MOM, WR, MY_ID, 64'h2, 1'b0);
        send_word(MOM, WR, MY_ID, 64'h3, 1'b1);
        send_word(EOM, WR, MY_ID, 64'h4, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (wq.size() != 3) begin n_bad++; $display("FAIL wrap_count got %0d exp 3", wq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < wq.size()) ? wq[i] : '1;
            n_cmp++; if (got !== ew[i]) begin n_bad++; $display("FAIL wrap_wr%0d got %h exp %h", i, got, ew[i]); end
        end
        n_cmp++; if (mwc__stat__pkt_cnt !== 16'd3) begin n_bad++; $display("FAIL wrap_pkt got %0d exp 3", mwc__stat__pkt_cnt); end
    endtask

    task automatic test_protocol();
        logic [87:0] ew [3];
        logic [87:0] got;
        ew[0] = {24'h000300, 64'h11};
        ew[1] = {24'h000400, 64'h21};
        ew[2] = {24'h000401, 64'h22};
        wq.delete(); wt.delete();
        send_word(MOM, WR, MY_ID, 64'h77, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (mwc__stat__err !== 1'b1) begin n_bad++; $display("FAIL proto_mom_err got %b exp 1", mwc__stat__err); end
        n_cmp++; if (wq.size() != 0) begin n_bad++; $display("FAIL proto_mom_writes got %0d exp 0", wq.size()); end
        send_word(SOM, WR, MY_ID, 64'h000300, 1'b0);
        send_word(MOM, WR, MY_ID, 64'h11, 1'b1);
        send_word(SOM, WR, MY_ID, 64'h000400, 1'b0);
        send_word(MOM, WR, MY_ID, 64'h21, 1'b1);
        send_word(EOM, WR, MY_ID, 64'h22, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (wq.size() != 3) begin n_bad++; $display("FAIL proto_count got %0d exp 3", wq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < wq.size()) ? wq[i] : '1;
            n_cmp++; if (got !== ew[i]) begin n_bad++; $display("FAIL proto_wr%0d got %h exp %h", i, got, ew[i]); end
        end
        n_cmp++; if (mwc__stat__pkt_cnt !== 16'd4) begin n_bad++; $display("FAIL proto_pkt got %0d exp 4", mwc__stat__pkt_cnt); end
        n_cmp++; if (mwc__stat__drop_cnt !== 16'd2) begin n_bad++; $display("FAIL proto_drop got %0d exp 2", mwc__stat__drop_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [87:0] ew [2];
        logic [87:0] got;
        ew[0] = {24'h000600, 64'h61};
        ew[1] = {24'h000601, 64'h62};
        wq.delete(); wt.delete();
        send_word(SOM, WR, MY_ID, 64'h000500, 1'b0);
        send_word(MOM, WR, MY_ID, 64'h51, 1'b1);
        send_word(MOM, WR, MY_ID, 64'h52, 1'b1);
        reset_poweron      = 1'b0;
        mcntl__mwc__valid  = 1'b1;
        mcntl__mwc__cntl   = MOM;
        mcntl__mwc__data   = 64'h53;
        mcntl__mwc__pvalid = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (mwc__mem__wr_en !== 1'b0) begin n_bad++; $display("FAIL rmid_wr_en got %b exp 0", mwc__mem__wr_en); end
        n_cmp++; if (mwc__mem__wr_addr !== 24'h0) begin n_bad++; $display("FAIL rmid_addr got %h exp 0", mwc__mem__wr_addr); end
        n_cmp++; if (mwc__mem__wr_data !== 64'h0) begin n_bad++; $display("FAIL rmid_data got %h exp 0", mwc__mem__wr_data); end
        n_cmp++; if (mwc__stat__pkt_cnt !== 16'h0) begin n_bad++; $display("FAIL rmid_pkt got %h exp 0", mwc__stat__pkt_cnt); end
        n_cmp++; if (mwc__stat__drop_cnt !== 16'h0) begin n_bad++; $display("FAIL rmid_drop got %h exp 0", mwc__stat__drop_cnt); end
        n_cmp++; if (mwc__stat__err !== 1'b0) begin n_bad++; $display("FAIL rmid_err got %b exp 0", mwc__stat__err); end
        n_cmp++; if (mwc__mcntl__ready !== 1'b0) begin n_bad++; $display("FAIL rmid_ready got %b exp 0", mwc__mcntl__ready); end
        mcntl__mwc__cntl = EOM;
        mcntl__mwc__data = 64'h54;
        @(posedge clk); #1;
        mcntl__mwc__valid = 1'b0;
        reset_poweron     = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        // only the first payload word made it out before reset; leftovers would raise err
        n_cmp++; if (wq.size() != 1) begin n_bad++; $display("FAIL rmid_pre_writes got %0d exp 1", wq.size()); end
        n_cmp++; if (mwc__stat__err !== 1'b0) begin n_bad++; $display("FAIL rmid_empty_err got %b exp 0", mwc__stat__err); end
        wq.delete(); wt.delete();
        send_word(SOM, WR, MY_ID, 64'h000600, 1'b0);
        send_word(MOM, WR, MY_ID, 64'h61, 1'b1);
        send_word(EOM, WR, MY_ID, 64'h62, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (wq.size() != 2) begin n_bad++; $display("FAIL rmid_count got %0d exp 2", wq.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < wq.size()) ? wq[i] : '1;
            n_cmp++; if (got !== ew[i]) begin n_bad++; $display("FAIL rmid_wr%0d got %h exp %h", i, got, ew[i]); end
        end
        n_cmp++; if (mwc__stat__pkt_cnt !== 16'd1) begin n_bad++; $display("FAIL rmid_post_pkt got %0d exp 1", mwc__stat__pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_filter();
        test_backpressure();
        test_wrap_sparse();
        test_protocol();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
